simmem_wresp_releaser: RTL and testbench
========================================

SIMMEM_WRESP_RELEASER -- requirements
Module: simmem_wresp_releaser

Interface
REQ-001 SHALL have parameter Capacity, default 8, number of write-response bank slots (matches simmem_pkg::WriteRespBankTotalCapacity).
REQ-002 SHALL have parameter DelayWidth, default 8, width of the per-slot delay value.
REQ-003 SHALL derive AddrWidth = clog2(Capacity) and CntWidth = clog2(Capacity+1) as localparams.
REQ-004 SHALL use one clock and an asynchronous active-low reset, listed first: clk_i input 1 clock; rst_ni input 1 asynchronous active-low reset.
REQ-005 rsv_fire_i  input  1  bank reservation handshake completed this cycle (rsv_valid & rsv_ready).
REQ-006 rsv_addr_i  input  AddrWidth  slot address returned by the bank for that reservation.
REQ-007 delay_i  input  DelayWidth  simulated latency in cycles for that reservation.
REQ-008 release_en_o  output  Capacity  multi-hot, one bit per slot, to the bank release_en input.
REQ-009 released_addr_onehot_i  input  Capacity  one-hot from the bank: slot whose response left this cycle.
REQ-010 num_pending_o  output  CntWidth  number of slots not IDLE.
REQ-011 err_o  output  1  sticky protocol-error flag.

Function
REQ-012 Each slot SHALL hold a 3-state FSM (IDLE, COUNT, READY) and a DelayWidth down-counter.
REQ-013 IDLE -> COUNT on rsv_fire_i with rsv_addr_i equal to the slot; counter loads delay_i.
REQ-014 In COUNT with counter nonzero, the counter SHALL decrement by 1 per cycle, without wrap.
REQ-015 In COUNT with counter zero, the slot SHALL move to READY on the next edge.
REQ-016 Latency: a fire at edge t with delay d SHALL cause release_en_o[slot] to be high first in the cycle after edge t+d+1; d=0 gives assertion one cycle after the fire edge.
REQ-017 release_en_o[i] SHALL be 1 exactly when slot i is READY; it is a registered state decode with no combinational path from any input.
REQ-018 READY -> IDLE when released_addr_onehot_i[i]=1.
REQ-019 A slot in READY SHALL hold release_en_o high indefinitely until released (bank backpressure).
REQ-020 Simultaneous release and fire on the same READY slot SHALL be accepted: slot goes to COUNT with the new delay.
REQ-021 A fire to a slot in COUNT, or in READY without same-cycle release, SHALL be ignored (state unchanged) and SHALL set err_o.
REQ-022 released_addr_onehot_i bit set for a slot not in READY SHALL be ignored and SHALL set err_o.
REQ-023 released_addr_onehot_i with more than one bit set SHALL set err_o; each set bit is still processed per REQ-018/REQ-022.
REQ-024 rsv_addr_i >= Capacity with rsv_fire_i SHALL be ignored and SHALL set err_o.
REQ-025 num_pending_o SHALL be registered and equal the count of non-IDLE slots after each edge; range 0..Capacity, never wraps.
REQ-026 Slots SHALL operate independently; any number may reach READY in the same cycle.
REQ-027 err_o, once set, SHALL stay 1 until reset.

Reset
REQ-028 On rst_ni low, asynchronously: all slots IDLE, counters 0, release_en_o=0, num_pending_o=0, err_o=0.
REQ-029 Reset asserted mid-operation SHALL discard all pending slots; no release_en_o bit asserts before a new fire after deassertion.
REQ-030 Deassertion SHALL be synchronous to clk_i via the standard deassertion path; the first fire is accepted at the first edge after deassertion.

Verification
REQ-031 Fire slot 3, delay 5, at edge 0 -> release_en_o=0x08 from the cycle after edge 6; holds until released_addr_onehot_i=0x08, then 0x00 next cycle; num_pending_o 1 -> 0.
REQ-032 Fire slot 0 delay 0, then slot 7 delay 0 on the next edge -> release_en_o 0x01 then 0x81; release both over two cycles -> 0x00; err_o stays 0.
REQ-033 All 8 slots fired with delay 2 over 8 consecutive edges -> num_pending_o reaches 8; release_en_o fills 0x01..0xFF; releasing one per cycle drains it to 0.
REQ-034 Slot 2 READY; same cycle released_addr_onehot_i=0x04 and fire slot 2 delay 3 -> slot 2 re-enters COUNT, release_en_o[2]=0 next cycle, reasserts 4 cycles later; err_o=0.
REQ-035 Fire slot 1 while in COUNT; release slot 5 while IDLE; released_addr_onehot_i=0x06 -> err_o=1 and stays 1; slot 1 timing unchanged.
REQ-036 Slot 4 COUNT with 10 remaining; pulse rst_ni low mid-count -> all outputs 0 immediately; no release_en_o bit for 20 cycles with no fire.

Source files
------------

// File: rtl/simmem_wresp_releaser.sv
// simmem_wresp_releaser: per-slot delay counters that release write responses held in the
// response bank once their simulated latency has elapsed. Rev 1.0
`default_nettype none

module simmem_wresp_releaser #(
   parameter  int Capacity   = 8,
   parameter  int DelayWidth = 8,
   localparam int AddrWidth  = $clog2(Capacity),
   localparam int CntWidth   = $clog2(Capacity + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  rsv_fire_i,
   input  logic [AddrWidth-1:0]  rsv_addr_i,
   input  logic [DelayWidth-1:0] delay_i,
   output logic [Capacity-1:0]   release_en_o,
   input  logic [Capacity-1:0]   released_addr_onehot_i,
   output logic [CntWidth-1:0]   num_pending_o,
   output logic                  err_o
);

   typedef enum logic [1:0] {
      SlotIdle  = 2'd0,
      SlotCount = 2'd1,
      SlotReady = 2'd2
   } slot_state_e;

   localparam logic [AddrWidth:0] CapLimit = (AddrWidth + 1)'(Capacity);

   slot_state_e           state_q [Capacity];
   slot_state_e           state_d [Capacity];
   logic [DelayWidth-1:0] cnt_q   [Capacity];
   logic [DelayWidth-1:0] cnt_d   [Capacity];
   logic [CntWidth-1:0]   pending_q, pending_d;
   logic                  err_q, err_d;
   logic                  addr_ok;
   logic                  fire_ok;
   logic                  hit;
   logic                  rel;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = '0;
      err_d     = err_q;
      hit       = 1'b0;
      rel       = 1'b0;
      addr_ok   = ({1'b0, rsv_addr_i} < CapLimit);
      fire_ok   = rsv_fire_i && addr_ok;

      if (rsv_fire_i && !addr_ok) begin
         err_d = 1'b1;
      end
      if ((released_addr_onehot_i & (released_addr_onehot_i - Capacity'(1))) != '0) begin
         err_d = 1'b1;
      end

      for (int i = 0; i < Capacity; i++) begin
         hit = fire_ok && (rsv_addr_i == AddrWidth'(i));
         rel = released_addr_onehot_i[i];
         case (state_q[i])
            SlotIdle: begin
               if (hit) begin
                  state_d[i] = SlotCount;
                  cnt_d[i]   = delay_i;
               end
               if (rel) begin
                  err_d = 1'b1;
               end
            end
            SlotCount: begin
               // The zero-count cycle is spent in COUNT, giving d+1 cycles before READY.
               if (cnt_q[i] != '0) begin
                  cnt_d[i] = cnt_q[i] - DelayWidth'(1);
               end else begin
                  state_d[i] = SlotReady;
               end
               if (hit || rel) begin
                  err_d = 1'b1;
               end
            end
            SlotReady: begin
               if (rel) begin
                  if (hit) begin
                     state_d[i] = SlotCount;
                     cnt_d[i]   = delay_i;
                  end else begin
                     state_d[i] = SlotIdle;
                  end
               end else if (hit) begin
                  err_d = 1'b1;
               end
            end
            default: begin
               state_d[i] = SlotIdle;
               cnt_d[i]   = '0;
            end
         endcase
      end

      for (int i = 0; i < Capacity; i++) begin
         if (state_d[i] != SlotIdle) begin
            pending_d = pending_d + CntWidth'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Capacity; i++) begin
            state_q[i] <= SlotIdle;
            cnt_q[i]   <= '0;
         end
         pending_q <= '0;
         err_q     <= 1'b0;
      end else begin
         for (int i = 0; i < Capacity; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      release_en_o = '0;
      for (int i = 0; i < Capacity; i++) begin
         release_en_o[i] = (state_q[i] == SlotReady);
      end
   end

   assign num_pending_o = pending_q;
   assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_simmem_wresp_releaser.sv
// tb_simmem_wresp_releaser: scoreboard bench comparing the releaser with a release-time model.
`default_nettype none

module tb_simmem_wresp_releaser;

   localparam int CAP = 8;
   localparam int DW  = 8;

   logic          clk;
   logic          rst_n;
   logic          fire;
   logic [2:0]    addr;
   logic [DW-1:0] delay;
   logic [CAP-1:0] rel_en;
   logic [CAP-1:0] released;
   logic [3:0]    pending;
   logic          err;

   simmem_wresp_releaser #(.Capacity(CAP), .DelayWidth(DW)) dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .rsv_fire_i             (fire),
      .rsv_addr_i             (addr),
      .delay_i                (delay),
      .release_en_o           (rel_en),
      .released_addr_onehot_i (released),
      .num_pending_o          (pending),
      .err_o                  (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [CAP-1:0] en;
      logic [3:0]     pend;
      logic           err;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Model: a busy slot is READY once the current edge index exceeds its release edge.
   bit m_busy [CAP];
   int m_rdy  [CAP];
   bit m_err;
   int n = 0;

   function automatic bit m_ready(int i);
      return m_busy[i] && (m_rdy[i] < n);
   endfunction

   function automatic logic [CAP-1:0] ready_mask();
      logic [CAP-1:0] m;
      m = '0;
      for (int i = 0; i < CAP; i++) m[i] = m_ready(i);
      return m;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < CAP; i++) begin
         m_busy[i] = 1'b0;
         m_rdy[i]  = 0;
      end
      m_err = 1'b0;
   endtask

   task automatic model_edge(input bit f, input int a, input int d, input logic [CAP-1:0] r,
                             output exp_t e);
      bit fi, ri, rdy;
      if ($countones(r) > 1) m_err = 1'b1;
      for (int i = 0; i < CAP; i++) begin
         fi  = f && (a == i);
         ri  = r[i];
         rdy = m_ready(i);
         if (!m_busy[i]) begin
            if (ri) m_err = 1'b1;
            if (fi) begin
               m_busy[i] = 1'b1;
               m_rdy[i]  = n + d + 1;
            end
         end else if (!rdy) begin
            if (fi || ri) m_err = 1'b1;
         end else if (ri) begin
            if (fi) m_rdy[i] = n + d + 1;
            else    m_busy[i] = 1'b0;
         end else if (fi) begin
            m_err = 1'b1;
         end
      end
      e.en   = '0;
      e.pend = '0;
      for (int i = 0; i < CAP; i++) begin
         e.en[i] = m_busy[i] && (m_rdy[i] <= n);
         if (m_busy[i]) e.pend = e.pend + 4'd1;
      end
      e.err = m_err;
      n++;
   endtask

   task automatic step(input bit f, input int a, input int d, input logic [CAP-1:0] r);
      exp_t e;
      #1;
      fire     = f;
      addr     = a[2:0];
      delay    = d[DW-1:0];
      released = r;
      model_edge(f, a, d, r, e);
      @(posedge clk);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int cycles);
      for (int k = 0; k < cycles; k++) step(1'b0, 0, 0, '0);
   endtask

   task automatic check_zero(input string tag);
      total++;
      if (rel_en !== '0 || pending !== '0 || err !== 1'b0) begin
         bad++;
         $display("FAIL %s: release_en=%h pending=%0d err=%b, required all zero",
                  tag, rel_en, pending, err);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < 10) begin
         @(negedge clk);
         k++;
      end
      #1;
      total++;
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
   endtask

   task automatic do_reset(input string tag);
      drain();
      rst_n = 1'b0;
      #1;
      check_zero(tag);
      model_clear();
      fire     = 1'b0;
      released = '0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (rel_en !== e.en) begin
            bad++;
            $display("FAIL release_en @%0t: got %h, required %h", $time, rel_en, e.en);
         end
         total++;
         if (pending !== e.pend) begin
            bad++;
            $display("FAIL num_pending @%0t: got %0d, required %0d", $time, pending, e.pend);
         end
         total++;
         if (err !== e.err) begin
            bad++;
            $display("FAIL err @%0t: got %b, required %b", $time, err, e.err);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CAP-1:0] r;
      bit f;
      int a;
      rst_n    = 1'b0;
      fire     = 1'b0;
      addr     = '0;
      delay    = '0;
      released = '0;
      model_clear();
      #1;
      check_zero("reset_state");
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Slot 3, delay 5, held until released.
      step(1'b1, 3, 5, '0);
      idle(8);
      step(1'b0, 0, 0, 8'h08);
      idle(2);

      // Back-to-back zero delays on slots 0 and 7.
      step(1'b1, 0, 0, '0);
      step(1'b1, 7, 0, '0);
      idle(1);
      step(1'b0, 0, 0, 8'h01);
      step(1'b0, 0, 0, 8'h80);
      idle(1);

      // Fill every slot, then drain one per cycle.
      for (int i = 0; i < CAP; i++) step(1'b1, i, 2, '0);
      idle(3);
      for (int i = 0; i < CAP; i++) step(1'b0, 0, 0, 8'(1 << i));
      idle(1);

      // Release and re-fire slot 2 in the same cycle.
      step(1'b1, 2, 0, '0);
      idle(2);
      step(1'b1, 2, 3, 8'h04);
      idle(5);
      step(1'b0, 0, 0, 8'h04);
      idle(1);

      // Clean random traffic: only legal fires and releases.
      for (int k = 0; k < 300; k++) begin
         r = ready_mask() & CAP'($urandom);
         f = 1'b0;
         a = $urandom_range(0, CAP - 1);
         if ($urandom_range(0, 1) == 1) begin
            if (!m_busy[a]) begin
               f = 1'b1;
            end else if (m_ready(a)) begin
               f    = 1'b1;
               r[a] = 1'b1;
            end
         end
         step(f, a, $urandom_range(0, 5), r);
      end
      do_reset("reset_after_clean");

      // Protocol errors: fire to COUNT, release of IDLE, multi-hot release.
      step(1'b1, 1, 6, '0);
      step(1'b1, 1, 2, '0);
      step(1'b0, 0, 0, 8'h20);
      step(1'b0, 0, 0, 8'h06);
      idle(8);
      step(1'b0, 0, 0, 8'h02);
      idle(2);

      // Reset mid-count discards the slot; nothing reasserts without a fire.
      do_reset("reset_after_err");
      step(1'b1, 4, 12, '0);
      idle(2);
      do_reset("reset_mid_count");
      idle(20);

      // Random traffic including illegal operations.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) r = CAP'($urandom);
         else                           r = ready_mask() & CAP'($urandom);
         step($urandom_range(0, 1) == 1, $urandom_range(0, CAP - 1), $urandom_range(0, 6), r);
      end
      idle(1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
